sample_window_avg: RTL and testbench
====================================

// Module: sample_window_avg
// PURPOSE
//  Parametrised sliding-window accumulator, the successor to the fixed-width
//  sample blocks. Accepts one WIDTH-bit unsigned sample per valid/ready beat,
//  keeps the last DEPTH samples in a circular buffer, and emits running sum and
//  mean. Sits between a sample source and downstream filters or decision logic.
// PARAMETERS
//  WIDTH  8  sample width in bits, unsigned, >=2
//  DEPTH  4  window length in samples, power of two, 2..256
//  (derived) LOG2D = $clog2(DEPTH); SUM_W = WIDTH+LOG2D
// PORTS
//  CLK        in   1      clock, rising edge
//  RST        in   1      asynchronous active-low reset
//  clear      in   1      synchronous window flush
//  in_valid   in   1      sample present
//  in_data    in   WIDTH  sample value
//  in_ready   out  1      block can take a sample this cycle
//  out_valid  out  1      result register holds a result
//  out_ready  in   1      downstream takes the result
//  out_sum    out  SUM_W  sum of samples currently in the window
//  out_avg    out  WIDTH  out_sum >> LOG2D, truncated
//  out_full   out  1      window holds DEPTH samples
// BEHAVIOUR
//  Reset (RST=0, any time, including mid-stream): wr_ptr, count, sum, out_sum,
//   out_avg, out_valid, out_full and out_peak all go to 0. Buffer contents are
//   left undefined because the count gate hides them.
//  in_ready = !clear && (!out_valid || out_ready). An accept is in_valid && in_ready.
//  On accept: buf[wr_ptr] <= in_data; wr_ptr <= wr_ptr+1 (wraps mod DEPTH);
//   count <= min(count+1, DEPTH);
//   sum_nxt = sum + in_data - (count==DEPTH ? buf[wr_ptr] : 0).
//   The oldest sample is read before it is overwritten in the same cycle.
//  Latency: one cycle. After an accept in cycle N, cycle N+1 shows out_valid=1,
//   out_sum=sum_nxt, out_avg=sum_nxt[SUM_W-1:LOG2D], and out_full=(count_nxt==DEPTH).
//  Before the window is full, empty slots count as zero, so the partial average
//   is sum/DEPTH, not sum/count.
//  Output hold: while out_valid && !out_ready, all outputs stay stable and
//   in_ready=0.
//  Output drain: out_valid drops when out_ready=1 and there is no accept that
//   cycle. Accept and drain in the same cycle keeps out_valid=1 with the new data.
//  clear=1 has priority over everything else. It zeroes wr_ptr, count, sum,
//   out_valid and out_full. in_ready=0, so a sample offered in that cycle is not taken.
//  Arithmetic: SUM_W cannot overflow (DEPTH*(2^WIDTH-1) fits). The subtract never
//   underflows.
// CONFIGURATION
//  SAMPLE_WIN_PEAK_EN defined:
//   - adds port out_peak (out, WIDTH): maximum accepted sample since the last
//     reset or clear;
//   - updates in the same cycle as out_sum;
//   - reset/clear value 0.
//  SAMPLE_WIN_PEAK_EN undefined: the port and its register are absent; all other
//   behaviour is identical.
// STRUCTURE
//  Package sample_win_pkg holds:
//   - parameter checks as localparam functions (power-of-two test, clog2);
//   - SUM_W derivation;
//   - a typedef for the count/pointer width.
//  Sub-module sample_win_buf holds the circular buffer: DEPTH x WIDTH registers
//   with one write port and one async read port at wr_ptr, and no reset on
//   the data.
//  The top holds the pointers, count, accumulator, handshake and output registers.
// TESTING (WIDTH=8, DEPTH=4, out_ready=1 unless stated)
//  1 Reset: assert RST=0 mid-stream -> all outputs 0 at once; in_ready=1 after release.
//  2 Fill: samples 10,20,30,40 -> out_sum 10,30,60,100; out_avg 2,7,15,25;
//    out_full rises with 100.
//  3 Slide: then sample 50 -> out_sum 140, out_avg 35, out_full 1.
//  4 Backpressure: out_ready=0 while out_valid -> in_ready=0 and outputs frozen
//    for 5 cycles; on release the next sample proceeds with no loss or duplicate.
//  5 Clear: clear=1 with in_valid=1, window full -> sample dropped, out_valid 0;
//    next sample 7 -> out_sum 7, out_avg 1, out_full 0.
//  6 Max values: 255 x5 -> out_sum 1020, out_avg 255.
//    With SAMPLE_WIN_PEAK_EN: samples 10,30,20 -> out_peak 10,30,30.

Source files
------------

// File: rtl/sample_win_pkg.sv
// ---------------------------------------------------------------------------
// sample_win_pkg
// Shared definitions for the sliding-window averager:
//   - is_pow2 / clog2_f : elaboration-time helpers for parameter checking
//   - sum_width         : accumulator width for a given sample width / depth
//   - win_cnt_t         : count/pointer carrier, wide enough for DEPTH = 256
// Optional feature macro used by the slice: SAMPLE_WIN_PEAK_EN (see top).
// ---------------------------------------------------------------------------
package sample_win_pkg;

    localparam int MAX_DEPTH = 256;

    // Nine bits hold counts 0..256 inclusive, which the largest window needs.
    typedef logic [8:0] win_cnt_t;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

    // DEPTH samples of (2^WIDTH - 1) each fit in WIDTH + log2(DEPTH) bits.
    function automatic int sum_width(input int w, input int d);
        return w + clog2_f(d);
    endfunction

endpackage

// File: rtl/sample_win_buf.sv
// ---------------------------------------------------------------------------
// sample_win_buf
// Circular sample store: DEPTH x WIDTH registers, one synchronous write port
// and one asynchronous read port sharing the same address. The read returns
// the value held before this cycle's write, which is how the oldest sample is
// fetched in the same cycle it gets replaced. Data is intentionally not reset.
// Ports:
//   CLK    in   1      clock, rising edge
//   we     in   1      write enable
//   addr   in   AW     shared read/write slot index
//   wdata  in   WIDTH  value written at addr
//   rdata  out  WIDTH  current content of slot addr
// ---------------------------------------------------------------------------
module sample_win_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Sample storage; contents before the first write are never observed
    // because the window count gates their use.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sample_window_avg.sv
// ---------------------------------------------------------------------------
// sample_window_avg
// Sliding-window accumulator: takes one unsigned WIDTH-bit sample per
// valid/ready beat, keeps the last DEPTH samples and presents the running sum
// and the sum divided by DEPTH (partial windows average over DEPTH, with
// empty slots counting as zero). Results appear one cycle after the accept.
// Ports:
//   CLK        in   1      clock, rising edge
//   RST        in   1      asynchronous active-low reset
//   clear      in   1      synchronous window flush, highest priority
//   in_valid   in   1      sample present
//   in_data    in   WIDTH  sample value
//   in_ready   out  1      block can take a sample this cycle
//   out_valid  out  1      result registers hold a result
//   out_ready  in   1      downstream takes the result
//   out_sum    out  SUM_W  sum of samples currently in the window
//   out_avg    out  WIDTH  out_sum >> LOG2D, truncated
//   out_full   out  1      window holds DEPTH samples
//   out_peak   out  WIDTH  only with SAMPLE_WIN_PEAK_EN: largest sample
//                          accepted since the last reset or clear
// Configuration macro: SAMPLE_WIN_PEAK_EN
// ---------------------------------------------------------------------------
module sample_window_avg
    import sample_win_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int LOG2D = clog2_f(DEPTH),
    localparam int SUM_W = sum_width(WIDTH, DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [WIDTH-1:0] out_avg,
    output logic             out_full
`ifdef SAMPLE_WIN_PEAK_EN
    ,
    output logic [WIDTH-1:0] out_peak
`endif
);

    // Reject unsupported configurations at elaboration.
    if (!is_pow2(DEPTH) || DEPTH < 2 || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $error("sample_window_avg: DEPTH must be a power of two in 2..256");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("sample_window_avg: WIDTH must be at least 2");
    end

    localparam win_cnt_t FULL_CNT = win_cnt_t'(DEPTH);

    logic [LOG2D-1:0] wr_ptr;
    win_cnt_t         count;
    win_cnt_t         count_nxt;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] sum_nxt;
    logic [WIDTH-1:0] oldest;
    logic             accept;
    logic             window_full;

    sample_win_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (LOG2D)
    ) u_buf (
        .CLK   (CLK),
        .we    (accept),
        .addr  (wr_ptr),
        .wdata (in_data),
        .rdata (oldest)
    );

    // A new sample may enter only when the result slot is free or being
    // drained this cycle; a flush blocks intake for its cycle.
    assign in_ready    = !clear && (!out_valid || out_ready);
    assign accept      = in_valid && in_ready;
    assign window_full = (count == FULL_CNT);

    // Once full, the slot at wr_ptr holds the oldest sample; its value leaves
    // the sum as the new one enters. Before that, nothing is retired.
    always_comb begin
        count_nxt = window_full ? count : win_cnt_t'(count + 9'd1);
        sum_nxt   = sum + SUM_W'(in_data) - (window_full ? SUM_W'(oldest) : '0);
    end

    // Window state and result registers. Flush leaves the last out_sum and
    // out_avg in place; out_valid=0 marks them as stale.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr    <= '0;
            count     <= '0;
            sum       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_avg   <= '0;
            out_full  <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            count     <= '0;
            sum       <= '0;
            out_valid <= 1'b0;
            out_full  <= 1'b0;
        end else if (accept) begin
            wr_ptr    <= wr_ptr + 1'b1;
            count     <= count_nxt;
            sum       <= sum_nxt;
            out_valid <= 1'b1;
            out_sum   <= sum_nxt;
            out_avg   <= sum_nxt[SUM_W-1:LOG2D];
            out_full  <= (count_nxt == FULL_CNT);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef SAMPLE_WIN_PEAK_EN
    // Running maximum, updated alongside out_sum.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_peak <= '0;
        end else if (clear) begin
            out_peak <= '0;
        end else if (accept && (in_data > out_peak)) begin
            out_peak <= in_data;
        end
    end
`endif

endmodule

// File: tb/tb_sample_window_avg.sv
// ---------------------------------------------------------------------------
// tb_sample_window_avg
// Self-checking bench for sample_window_avg (WIDTH=8, DEPTH=4). A queue-based
// window model is compared with the DUT on every falling edge; directed
// sequences pin the model with hand-computed literal values, then a random
// phase mixes samples, backpressure, flushes and resets.
// Honours SAMPLE_WIN_PEAK_EN to connect and check out_peak.
// ---------------------------------------------------------------------------
module tb_sample_window_avg;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int SUM_W = 10;

    logic             CLK = 1'b0;
    logic             RST;
    logic             clear;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sum;
    logic [WIDTH-1:0] out_avg;
    logic             out_full;
`ifdef SAMPLE_WIN_PEAK_EN
    logic [WIDTH-1:0] out_peak;
`endif

    int errors = 0;
    int checks = 0;

    sample_window_avg #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_avg   (out_avg),
        .out_full  (out_full)
`ifdef SAMPLE_WIN_PEAK_EN
        ,
        .out_peak  (out_peak)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one beat for one clock, then return 1 time unit after the edge.
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    // ---------------- behavioural model ----------------
    int   win[$];
    logic mValid;
    logic mFull;
    int   mSum;
    int   mAvg;
    int   mPeak;

    function automatic int winSum();
        int s;
        s = 0;
        foreach (win[i]) s += win[i];
        return s;
    endfunction

    task automatic modelReset();
        win.delete();
        mValid = 1'b0;
        mFull  = 1'b0;
        mSum   = 0;
        mAvg   = 0;
        mPeak  = 0;
    endtask

    initial modelReset();

    // Compare on the falling edge, then advance the model by what the next
    // rising edge will see (inputs only change just after rising edges).
    always @(negedge CLK) begin
        if (!RST) modelReset();
        checkOutput("in_ready",  in_ready,  !clear && (!mValid || out_ready));
        checkOutput("out_valid", out_valid, mValid);
        checkOutput("out_sum",   out_sum,   mSum);
        checkOutput("out_avg",   out_avg,   mAvg);
        checkOutput("out_full",  out_full,  mFull);
`ifdef SAMPLE_WIN_PEAK_EN
        checkOutput("out_peak",  out_peak,  mPeak);
`endif
        if (RST) begin
            if (clear) begin
                win.delete();
                mValid = 1'b0;
                mFull  = 1'b0;
                mPeak  = 0;
            end else if (in_valid && (!mValid || out_ready)) begin
                win.push_back(int'(in_data));
                if (win.size() > DEPTH) void'(win.pop_front());
                mSum   = winSum();
                mAvg   = mSum / DEPTH;
                mFull  = (win.size() == DEPTH);
                mValid = 1'b1;
                if (int'(in_data) > mPeak) mPeak = int'(in_data);
            end else if (out_ready) begin
                mValid = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        RST       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #2 RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;

        // Reset mid-stream
        applyStimulus(1'b1, 8'd10);
        applyStimulus(1'b1, 8'd20);
        checkOutput("pre_reset_sum", out_sum, 30);
        RST = 1'b0;
        #1;
        checkOutput("rst_sum",   out_sum,   0);
        checkOutput("rst_avg",   out_avg,   0);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_full",  out_full,  0);
        @(posedge CLK);
        #1 RST = 1'b1;
        #1;
        checkOutput("rst_in_ready", in_ready, 1);

        // Fill
        applyStimulus(1'b1, 8'd10);
        checkOutput("fill1_sum", out_sum, 10);  checkOutput("fill1_avg", out_avg, 2);
        checkOutput("fill1_full", out_full, 0);
        applyStimulus(1'b1, 8'd20);
        checkOutput("fill2_sum", out_sum, 30);  checkOutput("fill2_avg", out_avg, 7);
        applyStimulus(1'b1, 8'd30);
        checkOutput("fill3_sum", out_sum, 60);  checkOutput("fill3_avg", out_avg, 15);
        checkOutput("fill3_full", out_full, 0);
        applyStimulus(1'b1, 8'd40);
        checkOutput("fill4_sum", out_sum, 100); checkOutput("fill4_avg", out_avg, 25);
        checkOutput("fill4_full", out_full, 1);

        // Slide
        applyStimulus(1'b1, 8'd50);
        checkOutput("slide_sum", out_sum, 140); checkOutput("slide_avg", out_avg, 35);
        checkOutput("slide_full", out_full, 1);

        // Backpressure: offered sample must wait, outputs frozen
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'd60;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            checkOutput("bp_in_ready", in_ready, 0);
            checkOutput("bp_valid",    out_valid, 1);
            checkOutput("bp_sum",      out_sum, 140);
            checkOutput("bp_avg",      out_avg, 35);
        end
        out_ready = 1'b1;
        @(posedge CLK);
        #1 in_valid = 1'b0;
        checkOutput("bp_release_sum", out_sum, 180);
        checkOutput("bp_release_avg", out_avg, 45);
        @(posedge CLK);
        #1;
        checkOutput("drain_valid", out_valid, 0);
        checkOutput("drain_sum",   out_sum, 180);

        // Clear with a sample offered: the sample is dropped
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd99;
        @(posedge CLK);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        checkOutput("clr_valid", out_valid, 0);
        checkOutput("clr_full",  out_full, 0);
        applyStimulus(1'b1, 8'd7);
        checkOutput("clr_next_sum", out_sum, 7);
        checkOutput("clr_next_avg", out_avg, 1);
        checkOutput("clr_next_full", out_full, 0);

        // Maximum values
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'd255);
        checkOutput("max_sum",  out_sum, 1020);
        checkOutput("max_avg",  out_avg, 255);
        checkOutput("max_full", out_full, 1);

`ifdef SAMPLE_WIN_PEAK_EN
        clear = 1'b1;
        @(posedge CLK);
        #1 clear = 1'b0;
        checkOutput("peak_clr", out_peak, 0);
        applyStimulus(1'b1, 8'd10);
        checkOutput("peak1", out_peak, 10);
        applyStimulus(1'b1, 8'd30);
        checkOutput("peak2", out_peak, 30);
        applyStimulus(1'b1, 8'd20);
        checkOutput("peak3", out_peak, 30);
`endif

        // Random phase: model comparison runs every cycle
        for (int i = 0; i < 800; i++) begin
            clear     = ($urandom_range(0, 24) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       in_data = 8'd255;
                1:       in_data = 8'd0;
                default: in_data = 8'($urandom_range(0, 255));
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            RST       = ($urandom_range(0, 99) != 0);
            @(posedge CLK);
            #1;
        end

        RST       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
